// File: rtl/sw_pkg.sv
// Shared definitions for the packet read controller: FSM encoding, header
// field offsets and default widths.
package sw_pkg;

  localparam int DEF_DATA_BIT = 16;
  localparam int DEF_PORT_BIT = 2;
  localparam int DEF_LEN_BIT  = 8;
  localparam int DEF_TIMEOUT  = 255;

  // Header layout: destination port at the top of the word, length at the bottom.
  localparam int HDR_PORT_MSB = DEF_DATA_BIT - 1;
  localparam int HDR_LEN_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DROP = 2'd3
  } state_t;

endpackage

// File: rtl/pkt_rd_ctrl_if.sv
// Egress packet stream: out_valid/out_ready handshake; a beat transfers on a clock
// edge where both are high, and data/sop/eop stay stable while valid waits on ready.
interface pkt_rd_ctrl_if #(
  parameter int DATA_BIT = 16
) ();
  logic [DATA_BIT-1:0] out_data;
  logic                out_valid;
  logic                out_sop;
  logic                out_eop;
  logic                out_ready;

  modport master (output out_data, output out_valid, output out_sop, output out_eop,
                  input out_ready);
  modport slave  (input out_data, input out_valid, input out_sop, input out_eop,
                  output out_ready);
endinterface

// File: rtl/stream_out_reg.sv
// Registered valid/ready output stage carrying data plus sop/eop markers.
// A load is honoured only when the register is empty or being drained this cycle.
module stream_out_reg #(
  parameter int DATA_BIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DATA_BIT-1:0] load_data,
  input  logic                load_sop,
  input  logic                load_eop,
  input  logic                ready,
  output logic                can_load,
  output logic [DATA_BIT-1:0] data,
  output logic                valid,
  output logic                sop,
  output logic                eop
);
  logic [DATA_BIT-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;

  assign can_load = ~valid_q | ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (load && can_load) begin
      data_d  = load_data;
      valid_d = 1'b1;
      sop_d   = load_sop;
      eop_d   = load_eop;
    end else if (valid_q && ready) begin
      // Beat drained with nothing behind it; data is left as-is.
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign sop   = sop_q;
  assign eop   = eop_q;
endmodule

// File: rtl/pkt_rd_ctrl.sv
// Read-side FIFO consumer: pops a header, requests a switch port, streams the packet.
// Optional grant-wait timeout with payload drop is enabled by PKT_TIMEOUT_EN.
module pkt_rd_ctrl
  import sw_pkg::*;
#(
  parameter int DATA_BIT = DEF_DATA_BIT,
  parameter int PORT_BIT = DEF_PORT_BIT,
  parameter int LEN_BIT  = DEF_LEN_BIT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_BIT-1:0] fifo_rd_data,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  output logic                sw_req,
  output logic [PORT_BIT-1:0] sw_port,
  input  logic                sw_gnt,
  pkt_rd_ctrl_if.master       out_if,
  output logic                drop_pulse,
  output state_t              dbg_state
);
  localparam int PORT_MSB = HDR_PORT_MSB + (DATA_BIT - DEF_DATA_BIT);

  if (PORT_BIT + LEN_BIT > DATA_BIT || TIMEOUT < 1) begin : g_bad_cfg
    $error("pkt_rd_ctrl: header fields exceed DATA_BIT or TIMEOUT < 1");
  end

  state_t              state_q, state_d;
  logic [DATA_BIT-1:0] hdr_q, hdr_d;
  logic [LEN_BIT-1:0]  rem_q, rem_d;
  logic                sw_req_q, sw_req_d;
  logic [PORT_BIT-1:0] sw_port_q, sw_port_d;
  logic                drop_q, drop_d;
  logic                rd_en;
  logic                ld, ld_sop, ld_eop, can_load;
  logic [DATA_BIT-1:0] ld_data;
  logic [DATA_BIT-1:0] so_data;
  logic                so_valid, so_sop, so_eop;

`ifdef PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_q, wait_d;
`endif

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    rem_d     = rem_q;
    sw_req_d  = sw_req_q;
    sw_port_d = sw_port_q;
    drop_d    = 1'b0;
    rd_en     = 1'b0;
    ld        = 1'b0;
    ld_data   = fifo_rd_data;
    ld_sop    = 1'b0;
    ld_eop    = 1'b0;
`ifdef PKT_TIMEOUT_EN
    wait_d    = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          rd_en     = 1'b1;
          hdr_d     = fifo_rd_data;
          rem_d     = fifo_rd_data[HDR_LEN_LSB +: LEN_BIT];
          sw_port_d = fifo_rd_data[PORT_MSB -: PORT_BIT];
          sw_req_d  = 1'b1;
          state_d   = REQ;
`ifdef PKT_TIMEOUT_EN
          wait_d    = '0;
`endif
        end
      end
      REQ: begin
        // A grant on the timeout cycle still wins.
        if (sw_gnt) begin
          ld      = 1'b1;
          ld_data = hdr_q;
          ld_sop  = 1'b1;
          ld_eop  = (rem_q == '0);
          state_d = XFER;
        end
`ifdef PKT_TIMEOUT_EN
        else if (wait_q == TW'(TIMEOUT - 1)) begin
          sw_req_d = 1'b0;
          drop_d   = 1'b1;
          state_d  = DROP;
        end else begin
          wait_d = wait_q + TW'(1);
        end
`endif
      end
      XFER: begin
        if (rem_q != '0 && !fifo_empty && can_load) begin
          rd_en  = 1'b1;
          ld     = 1'b1;
          ld_eop = (rem_q == LEN_BIT'(1));
          rem_d  = rem_q - LEN_BIT'(1);
        end
        // Grant is treated as held until the eop beat leaves.
        if (so_valid && out_if.out_ready && so_eop) begin
          sw_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
`ifdef PKT_TIMEOUT_EN
      DROP: begin
        if (rem_q != '0) begin
          if (!fifo_empty) begin
            rd_en = 1'b1;
            rem_d = rem_q - LEN_BIT'(1);
          end
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hdr_q     <= '0;
      rem_q     <= '0;
      sw_req_q  <= 1'b0;
      sw_port_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      rem_q     <= rem_d;
      sw_req_q  <= sw_req_d;
      sw_port_q <= sw_port_d;
      drop_q    <= drop_d;
    end
  end

`ifdef PKT_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`endif

  stream_out_reg #(.DATA_BIT(DATA_BIT)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .load_data (ld_data),
    .load_sop  (ld_sop),
    .load_eop  (ld_eop),
    .ready     (out_if.out_ready),
    .can_load  (can_load),
    .data      (so_data),
    .valid     (so_valid),
    .sop       (so_sop),
    .eop       (so_eop)
  );

  assign out_if.out_data  = so_data;
  assign out_if.out_valid = so_valid;
  assign out_if.out_sop   = so_sop;
  assign out_if.out_eop   = so_eop;

  assign fifo_rd_en = rd_en & ~rst;
  assign sw_req     = sw_req_q;
  assign sw_port    = sw_port_q;
  assign drop_pulse = drop_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_pkt_rd_ctrl.sv
// Bench for pkt_rd_ctrl: show-ahead FIFO model, grant driver, beat scoreboard.
// Build with PKT_TIMEOUT_EN to also exercise the grant timeout and drop path.
module tb_pkt_rd_ctrl;
  import sw_pkg::*;

  localparam int DW = 16;
  localparam int PW = 2;
  localparam int LW = 8;
  localparam int W  = DW + 2;
`ifdef PKT_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          sw_req;
  logic [PW-1:0] sw_port;
  logic          sw_gnt;
  logic          drop_pulse;
  state_t        dbg_state;

  pkt_rd_ctrl_if #(.DATA_BIT(DW)) out_if ();

  pkt_rd_ctrl #(.DATA_BIT(DW), .PORT_BIT(PW), .LEN_BIT(LW), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .sw_req       (sw_req),
    .sw_port      (sw_port),
    .sw_gnt       (sw_gnt),
    .out_if       (out_if.master),
    .drop_pulse   (drop_pulse),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] fifo_q[$];
  logic [W-1:0]  exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, pop_cnt = 0, beat_cnt = 0, req_cnt = 0, drop_cnt = 0;
  int gap_cnt = 0, valid_cnt = 0, first_beat_cyc = 0, last_beat_cyc = 0;
  bit ready_toggle = 1'b0;
  int tog_idx = 0;
  logic [3:0] rdy_pat = 4'b1001;
  logic prev_stall = 1'b0;
  logic [W-1:0] held = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIFO pops happen on the clock edge where the DUT strobes fifo_rd_en.
  always @(posedge clk) begin
    cyc++;
    if (out_if.out_valid && !out_if.out_ready)
      check_eq("no_pop_stall", {31'd0, fifo_rd_en}, 32'd0);
    if (fifo_rd_en) begin
      check_eq("pop_nonempty", {31'd0, fifo_q.size() != 0}, 32'd1);
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pop_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_toggle) begin
      out_if.out_ready = rdy_pat[tog_idx];
      tog_idx = (tog_idx + 1) % 4;
    end
  end

  // Mid-cycle: refresh FIFO head, then score the beat the next edge will accept.
  always @(negedge clk) begin
    logic [W-1:0] exp_beat;
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (sw_req) req_cnt++;
      if (drop_pulse) drop_cnt++;
      if (out_if.out_valid) valid_cnt++;
      if (dbg_state == XFER && !out_if.out_valid) gap_cnt++;
      if (prev_stall)
        check_eq("hold_stable", {13'd0, out_if.out_valid, out_if.out_sop, out_if.out_eop, out_if.out_data},
                 {13'd0, 1'b1, held});
      prev_stall = out_if.out_valid & ~out_if.out_ready;
      held = {out_if.out_sop, out_if.out_eop, out_if.out_data};
      if (out_if.out_valid && out_if.out_ready) begin
        check_eq("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_beat = exp_q.pop_front();
          check_eq("beat", {14'd0, out_if.out_sop, out_if.out_eop, out_if.out_data}, {14'd0, exp_beat});
        end
        if (out_if.out_sop) first_beat_cyc = cyc;
        if (out_if.out_eop) last_beat_cyc = cyc;
        beat_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_pkt(input logic [DW-1:0] hdr, input logic [DW-1:0] base, input int n_first,
                         input int gap, input int gnt_dly, input bit chk_timing);
    int len;
    logic [DW-1:0] pl[$];
    len = int'(hdr[LW-1:0]);
    for (int i = 0; i < len; i++)
      pl.push_back((base == '0) ? DW'($urandom_range(0, 65535)) : base + DW'(i));
    req_cnt = 0; gap_cnt = 0; beat_cnt = 0;
    fifo_q.push_back(hdr);
    exp_q.push_back({1'b1, len == 0, hdr});
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({1'b0, i == len - 1, pl[i]});
      if (i < n_first) fifo_q.push_back(pl[i]);
    end
    for (int i = 0; i < 50 && !sw_req; i++) tick();
    check_eq("req_rise", {31'd0, sw_req}, 32'd1);
    check_eq("sw_port", {30'd0, sw_port}, {30'd0, hdr[DW-1 -: PW]});
    repeat (gnt_dly) tick();
    sw_gnt = 1'b1;
    if (n_first < len) begin
      for (int i = 0; i < 200 && fifo_q.size() != 0; i++) tick();
      repeat (gap) tick();
      for (int i = n_first; i < len; i++) fifo_q.push_back(pl[i]);
    end
    for (int i = 0; i < 1200 && sw_req; i++) tick();
    check_eq("req_fall", {31'd0, sw_req}, 32'd0);
    sw_gnt = 1'b0;
    check_eq("sb_drained", exp_q.size(), 32'd0);
    check_eq("beat_count", beat_cnt, len + 1);
    if (chk_timing) begin
      check_eq("req_cycles", req_cnt, 2 + gnt_dly + len);
      check_eq("beat_span", last_beat_cyc - first_beat_cyc, len);
    end
    if (gap > 0) check_eq("gap_seen", {31'd0, gap_cnt != 0}, 32'd1);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, {31'd0, out_if.out_valid}, 32'd0);
    check_eq({tag, "_sop_eop"}, {30'd0, out_if.out_sop, out_if.out_eop}, 32'd0);
    check_eq({tag, "_data"}, {16'd0, out_if.out_data}, 32'd0);
    check_eq({tag, "_req_port"}, {29'd0, sw_req, sw_port}, 32'd0);
    check_eq({tag, "_drop_rden"}, {30'd0, drop_pulse, fifo_rd_en}, 32'd0);
    check_eq({tag, "_state"}, {30'd0, dbg_state}, {30'd0, IDLE});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    sw_gnt = 1'b0;
    out_if.out_ready = 1'b1;
    fifo_empty = 1'b1;
    fifo_rd_data = '0;
    #1;
    check_reset_outputs("reset");
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_pkt(16'h4003, 16'h00A1, 3, 0, 2, 1'b1);
    run_pkt(16'hC000, 16'h0000, 0, 0, 0, 1'b1);

    ready_toggle = 1'b1; tog_idx = 0;
    run_pkt(16'h8004, 16'h0000, 4, 0, 1, 1'b0);
    ready_toggle = 1'b0; out_if.out_ready = 1'b1;

    run_pkt(16'h0003, 16'h0000, 1, 3, 0, 1'b0);
    run_pkt(16'h40FF, 16'h0000, 255, 0, 0, 1'b1);

    for (int k = 0; k < 4; k++) begin
      ready_toggle = ($urandom_range(0, 1) == 1);
      run_pkt({PW'($urandom_range(0, 3)), 6'd0, LW'($urandom_range(0, 6))}, 16'h0000,
              64, 0, $urandom_range(0, 3), 1'b0);
      ready_toggle = 1'b0; out_if.out_ready = 1'b1;
    end

    // Reset in the middle of a transfer.
    beat_cnt = 0;
    fifo_q.push_back(16'h4005);
    for (int i = 0; i < 5; i++) fifo_q.push_back(DW'(16'h0B00 + i));
    exp_q.push_back({2'b10, 16'h4005});
    exp_q.push_back({2'b00, 16'h0B00});
    for (int i = 0; i < 50 && !sw_req; i++) tick();
    check_eq("mid_req_rise", {31'd0, sw_req}, 32'd1);
    sw_gnt = 1'b1;
    for (int i = 0; i < 50 && beat_cnt < 2; i++) tick();
    check_eq("mid_beats", beat_cnt, 2);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    fifo_q.delete();
    exp_q.delete();
    sw_gnt = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run_pkt(16'h4002, 16'h0000, 2, 0, 1, 1'b1);

`ifdef PKT_TIMEOUT_EN
    pop_cnt = 0; req_cnt = 0; drop_cnt = 0; valid_cnt = 0;
    fifo_q.push_back(16'h4002);
    fifo_q.push_back(16'h1111);
    fifo_q.push_back(16'h2222);
    for (int i = 0; i < 50 && drop_cnt == 0; i++) tick();
    for (int i = 0; i < 50 && dbg_state != IDLE; i++) tick();
    repeat (3) tick();
    check_eq("to_drop_once", drop_cnt, 1);
    check_eq("to_req_cycles", req_cnt, TB_TIMEOUT);
    check_eq("to_pops", pop_cnt, 3);
    check_eq("to_no_valid", valid_cnt, 0);
    check_eq("to_state", {30'd0, dbg_state}, {30'd0, IDLE});
`endif

    check_eq("final_sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pkt_rd_ctrl.md
Name: pkt_rd_ctrl

Overview:
- Read-side consumer of the ingress clock-domain-crossing FIFO, in the read-clock domain.
- Pops a header word from the FIFO's show-ahead output and requests the target switch port from the shared-cache arbiter.
- After grant, streams header plus payload as a valid/ready packet with sop/eop, then releases the port.

Parameters:
- DATA_BIT, 16, FIFO word and output data width.
- PORT_BIT, 2, width of the destination port field; header bits [DATA_BIT-1 -: PORT_BIT].
- LEN_BIT, 8, width of the payload-length field; header bits [LEN_BIT-1:0], counted in words, 0 legal. Requires PORT_BIT+LEN_BIT <= DATA_BIT.
- TIMEOUT, 255, grant-wait limit in cycles; used only with PKT_TIMEOUT_EN.

Ports:
- clk  in  1  read-domain clock.
- rst  in  1  asynchronous, active-high reset.
- fifo_rd_data  in  DATA_BIT  FIFO head word; valid combinationally whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  DATA_BIT? no: 1  FIFO pop strobe; combinational.
- sw_req  out  1  port request to the arbiter; held through the whole packet.
- sw_port  out  PORT_BIT  requested port; stable while sw_req=1.
- sw_gnt  in  1  grant, level; sampled only in REQ.
- out_data  out  DATA_BIT  registered packet word.
- out_valid  out  1  registered beat valid.
- out_sop  out  1  first beat (header).
- out_eop  out  1  last beat.
- out_ready  in  1  downstream accept.
- drop_pulse  out  1  one-cycle drop indication; tied 0 without PKT_TIMEOUT_EN.

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE.
  - Outputs go to 0: sw_req, sw_port, out_valid, out_sop, out_eop, out_data, drop_pulse.
  - Header and remaining-beat count registers clear.
  - fifo_rd_en=0 while rst=1.
- States: IDLE, REQ, XFER, plus DROP (feature only).
- IDLE:
  - fifo_rd_en=1 whenever fifo_empty=0.
  - That same edge captures fifo_rd_data into hdr_reg and sets rem = hdr[LEN_BIT-1:0].
  - Drives sw_port <= hdr port field, sw_req <= 1, state -> REQ.
  - sw_req is first seen high one cycle after the pop.
- REQ:
  - fifo_rd_en=0.
  - On sw_gnt=1, the same edge loads the output register: out_data<=hdr, out_valid<=1, out_sop<=1, out_eop<=(rem==0). State -> XFER.
- XFER, output-register rule:
  - The register may load only when out_valid=0 or out_ready=1.
  - Accepted beat = out_valid & out_ready.
- XFER, payload:
  - fifo_rd_en = (rem!=0) & ~fifo_empty & (~out_valid | out_ready).
  - A pop loads out_data<=fifo_rd_data, out_valid<=1, out_sop<=0, out_eop<=(rem==1), and decrements rem.
  - An accepted beat with no pop clears out_valid.
- FIFO underrun mid-packet: out_valid drops to 0 and the packet resumes when data arrives. No bubbles are inserted when data is available, so with out_ready=1 throughput is 1 word per cycle.
- End of packet: on the edge that accepts the eop beat, sw_req<=0, out_eop<=0, out_valid<=0, state -> IDLE. The next header can pop in the following cycle, so there is one idle cycle between packets.
- Backpressure: out_data, out_sop and out_eop are held stable while out_valid=1 and out_ready=0.
- Header-only packet (len=0): a single beat with sop=1 and eop=1.
- Arithmetic: rem is LEN_BIT wide and never decrements below 0. Maximum packet is 2**LEN_BIT words including the header.
- sw_gnt deasserted during XFER is ignored; the grant is considered held until eop.
- Reset mid-packet: the FIFO contents are not flushed by this block. The FIFO shares the reset domain and clears itself.

Optional Feature:
- Macro: PKT_TIMEOUT_EN.
- With the macro:
  - A wait counter runs in REQ, cleared on REQ entry.
  - If TIMEOUT cycles elapse with no grant: sw_req<=0, drop_pulse<=1 for one cycle, state -> DROP.
  - DROP pops rem payload words (fifo_rd_en = (rem!=0) & ~fifo_empty) with no output beats, then goes to IDLE.
  - A grant arriving on the timeout cycle wins.
- Without the macro: no counter and no DROP state; drop_pulse is constant 0; REQ waits indefinitely.

Decomposition:
- Shared package sw_pkg holds:
  - State encoding (IDLE=0, REQ=1, XFER=2, DROP=3).
  - Header field offset constants (HDR_PORT_MSB, HDR_LEN_LSB).
  - Default widths.
- One natural sub-module: stream_out_reg, the output data/sop/eop/valid register with load/accept logic, reusable on other egress paths.

Test Plan:
- Header 16'h4003 (port 1, len 3) then payload A1,A2,A3, sw_gnt 2 cycles after sw_req, out_ready=1.
  -> sw_port=1; beats 4003(sop),A1,A2,A3(eop) on consecutive cycles; sw_req falls after A3.
- Header 16'hC000 (port 3, len 0) -> single beat, sop=eop=1; sw_req high for exactly the REQ and XFER cycles.
- Len 4 packet with out_ready toggling 1,0,0,1,... -> data held stable while stalled; 5 beats delivered in order; no FIFO pops while the output is full and stalled.
- Len 3 packet with the FIFO empty for 3 cycles after the first payload word -> out_valid gaps; eop still on the 3rd payload word; rem correct.
- rst asserted mid-XFER after 2 beats -> all outputs 0 immediately; after release, a new header is processed from IDLE.
- With PKT_TIMEOUT_EN and TIMEOUT=8, sw_gnt held 0, len 2 -> drop_pulse once at the 8th REQ cycle; 2 payload words popped; no out_valid; then back to IDLE.
